// File: rtl/mar_pkg.sv
// Shared types and helpers for the memory-address-register unit.
// Used by mar_src_mux and mar_unit.
package mar_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mar_state_e;

   localparam int unsigned MAR_RESET_ADDR_DEFAULT = 0;

   // Bit offset of source idx inside a packed bus of width-bit sources.
   function automatic int unsigned src_lsb(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/mar_src_mux.sv
// N-way address source selector. An out-of-range select yields zero and
// raises sel_invalid_o, matching the old default-to-zero mux.
module mar_src_mux
   import mar_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
   input  logic [SEL_W-1:0]          sel_i,
   output logic [ADDR_W-1:0]         addr_o,
   output logic                      sel_invalid_o
);

   logic [ADDR_W-1:0]  src_arr [NUM_SRC];
   logic [NUM_SRC-1:0] hit;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign src_arr[gi] = src_addr_i[src_lsb(gi, ADDR_W) +: ADDR_W];
         assign hit[gi]     = (sel_i == SEL_W'(gi));
      end
   endgenerate

   // AND-OR selection keeps out-of-range selects at zero without indexing past the array.
   always_comb begin
      addr_o = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hit[i]) begin
            addr_o = addr_o | src_arr[i];
         end
      end
   end

   assign sel_invalid_o = ~|hit;

endmodule

// File: rtl/mar_unit.sv
// Memory address register with source select, increment/wrap and a req/ack access.
// Optional MAR_AUTOINC_EN adds auto_inc: post-increment the MAR in the DONE cycle.
module mar_unit
   import mar_pkg::*;
#(
   parameter int                ADDR_W     = 16,
   parameter int                NUM_SRC    = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(MAR_RESET_ADDR_DEFAULT),
   localparam int               SEL_W      = $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
   input  logic [SEL_W-1:0]          src_sel,
   input  logic                      load,
   input  logic                      inc,
`ifdef MAR_AUTOINC_EN
   input  logic                      auto_inc,
`endif
   output logic                      cmd_ready,
   output logic [ADDR_W-1:0]         mar_out,
   output logic                      mem_req,
   input  logic                      mem_ack,
   output logic                      done,
   output logic                      wrap,
   output logic                      sel_err
);

   mar_state_e        state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic              wrap_q, wrap_d;
   logic              sel_err_q, sel_err_d;
`ifdef MAR_AUTOINC_EN
   logic              auto_q, auto_d;
`endif

   logic [ADDR_W-1:0] mux_addr;
   logic              mux_invalid;
   logic [ADDR_W:0]   inc_sum;

   mar_src_mux #(
      .ADDR_W  (ADDR_W),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_src_mux (
      .src_addr_i    (src_addr),
      .sel_i         (src_sel),
      .addr_o        (mux_addr),
      .sel_invalid_o (mux_invalid)
   );

   // Carry out of the increment marks the all-ones to zero rollover.
   assign inc_sum = {1'b0, mar_q} + {{ADDR_W{1'b0}}, 1'b1};

   always_comb begin
      state_d   = state_q;
      mar_d     = mar_q;
      wrap_d    = wrap_q;
      sel_err_d = 1'b0;
`ifdef MAR_AUTOINC_EN
      auto_d    = auto_q;
`endif
      case (state_q)
         IDLE: begin
            if (load) begin
               mar_d     = mux_addr;
               wrap_d    = 1'b0;
               sel_err_d = mux_invalid;
               state_d   = REQ;
`ifdef MAR_AUTOINC_EN
               auto_d    = auto_inc;
`endif
            end else if (inc) begin
               mar_d   = inc_sum[ADDR_W-1:0];
               wrap_d  = wrap_q | inc_sum[ADDR_W];
               state_d = REQ;
`ifdef MAR_AUTOINC_EN
               auto_d  = auto_inc;
`endif
            end
         end
         REQ: begin
            if (mem_ack) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef MAR_AUTOINC_EN
            if (auto_q) begin
               mar_d  = inc_sum[ADDR_W-1:0];
               wrap_d = wrap_q | inc_sum[ADDR_W];
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mar_q     <= RESET_ADDR;
         wrap_q    <= 1'b0;
         sel_err_q <= 1'b0;
`ifdef MAR_AUTOINC_EN
         auto_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mar_q     <= mar_d;
         wrap_q    <= wrap_d;
         sel_err_q <= sel_err_d;
`ifdef MAR_AUTOINC_EN
         auto_q    <= auto_d;
`endif
      end
   end

   // All status outputs decode straight from registered state.
   assign cmd_ready = (state_q == IDLE);
   assign mem_req   = (state_q == REQ);
   assign done      = (state_q == DONE);
   assign mar_out   = mar_q;
   assign wrap      = wrap_q;
   assign sel_err   = sel_err_q;

endmodule

// File: doc/mar_unit.md
Name: mar_unit

Overview:
- Parametrised memory-address-register unit. Selects one of NUM_SRC address sources (PC, data bus, IR operand, stack pointer, ...) and registers the result as the MAR.
- Issues a req/ack memory access for each new address.
- Supports increment with wrap detection, so the control unit can issue sequential fetches without reloading.
- Sits between the address-source datapath and the memory interface.

Parameters:
- ADDR_W, 16, address width in bits.
- NUM_SRC, 4, number of address sources (>=2).
- SEL_W, $clog2(NUM_SRC), source-select width (derived localparam).
- RESET_ADDR, 0, MAR value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- src_addr  in  NUM_SRC*ADDR_W  packed sources; source i at bits [i*ADDR_W +: ADDR_W].
- src_sel  in  SEL_W  source index for load.
- load  in  1  load MAR from src_addr[src_sel], then access memory.
- inc  in  1  MAR <= MAR+1, then access memory.
- cmd_ready  out  1  high in IDLE; commands are accepted only when high.
- mar_out  out  ADDR_W  registered MAR, drives the memory address.
- mem_req  out  1  access request to memory.
- mem_ack  in  1  memory completion, one cycle.
- done  out  1  one-cycle pulse the cycle after mem_ack is seen.
- wrap  out  1  sticky; set when an increment rolls over from all-ones to 0.
- sel_err  out  1  one-cycle pulse on a load with src_sel >= NUM_SRC.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset: mar_out=RESET_ADDR, mem_req=0, done=0, wrap=0, sel_err=0, cmd_ready=1, state=IDLE. Reset mid-access drops mem_req on the next edge, and any late mem_ack is ignored.
- FSM states: IDLE, REQ, DONE.
  - IDLE -> REQ on load or inc.
  - REQ -> DONE on mem_ack.
  - DONE -> IDLE unconditionally.
- Load in IDLE at edge N:
  - mar_out = selected source from N+1.
  - mem_req=1 from N+1.
- Invalid select (src_sel >= NUM_SRC):
  - MAR loads 0, sel_err pulses at N+1.
  - The access still proceeds, preserving the legacy mux's default-to-zero behaviour.
- Increment in IDLE:
  - MAR <= MAR+1, modulo 2^ADDR_W.
  - If MAR was all-ones: MAR becomes 0 and wrap is set.
  - wrap clears only on reset or on a load.
- load and inc together: load wins, inc is ignored.
- Commands while cmd_ready=0 are ignored. The MAR is never modified outside IDLE, except by the optional feature.
- mem_req stays high and mar_out stays stable until mem_ack is sampled. mem_ack outside REQ is ignored.
- mem_ack in the first REQ cycle is legal: mem_req falls and done pulses the next cycle.
- Minimum command-to-command spacing is 3 cycles (IDLE, REQ, DONE).

Optional Feature:
- Macro: MAR_AUTOINC_EN.
- With the macro defined:
  - Adds input auto_inc (1 bit), sampled with the command.
  - When auto_inc was set, the MAR post-increments in the DONE cycle. Wrap rules are the same as for inc.
  - A subsequent inc then accesses address+2, not address+1.
- Without the macro: the port is absent and the MAR holds its value after an access.

Decomposition:
- Package mar_pkg holds:
  - state enum {IDLE, REQ, DONE} (2-bit);
  - localparam for RESET_ADDR default;
  - helper function for source-slice extraction.
- One sub-module, mar_src_mux: the generalised N-way combinational selector.
  - Outputs the selected source and sel_invalid.
  - Outputs 0 when the select is out of range.

Test Plan:
- Reset then idle: after rst high for 2 cycles, mar_out=0x0000, mem_req=0, cmd_ready=1, wrap=0.
- Load source 2 = 0x1234, ack after 3 cycles:
  - mar_out=0x1234 and mem_req=1 at N+1;
  - mem_req holds for 3 cycles;
  - done pulses once, then cmd_ready=1.
- MAR=0xFFFF, inc, immediate ack: mar_out=0x0000, wrap=1. A following load of 0x0010 clears wrap.
- Simultaneous load and inc with source 1 = 0x00A0: mar_out=0x00A0, not 0x00A1. A load issued during REQ is ignored and the MAR is unchanged.
- NUM_SRC=3, src_sel=3: sel_err pulses, mar_out=0x0000, the access completes normally.
- Reset asserted while mem_req=1: the next edge gives mem_req=0 and mar_out=RESET_ADDR, and a stray mem_ack does not produce done. With MAR_AUTOINC_EN and auto_inc=1, a load of 0x0100 leaves mar_out=0x0101 after done.
